serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in through a start/busy handshake.
- Drives one shared 1-bit full-adder cell over WIDTH cycles, LSB first, and keeps the running carry in a flop.
- Returns sum, carry-out and a one-cycle done pulse.
- Used wherever area matters more than latency; it replaces a WIDTH-bit ripple adder with one full-adder cell plus control.

---
 rtl/serial_add_ctrl_pkg.sv | 15 +
 rtl/serial_add_ctrl_if.sv | 38 +++
 rtl/serial_add_ctrl_fa_cell.sv | 15 +
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial adder sequencer: FSM state
//   encodings and the default operand width.
//   Optional feature macro used by this slice: SERIAL_ADD_SUB_EN.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Request/result bundle of the bit-serial adder.
//   master : requester (drives start, a, b, cin[, sub]; sees busy, done, sum, cout)
//   slave  : serial_add_ctrl (the opposite directions)
//   With SERIAL_ADD_SUB_EN defined, a 1-bit sub request is carried as well.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell
//   Combinational 1-bit full adder shared by every bit position of the
//   serial adder.
//   a, b, cin : addend bits and incoming carry
//   s, c      : sum bit and outgoing carry
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. An accepted start latches both operands and
//   the carry-in, then one full-adder cell is stepped over WIDTH cycles,
//   LSB first. The result is shifted into sum from the MSB side, so after
//   WIDTH steps bit 0 has reached position 0. A one-cycle done pulse marks
//   the result valid; sum/cout hold until the next accepted start.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : serial_add_ctrl_if.slave (start, a, b, cin[, sub] in;
//            busy, done, sum, cout out)
//   Optional feature macro: SERIAL_ADD_SUB_EN -- adds bus.sub; when set on
//   the accepting edge, b is inverted as latched and the carry is forced to
//   1, producing a-b (cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_ctrl_if.slave     bus
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_sh_reg, b_sh_reg, sum_reg;
  logic               carry_reg, cout_reg;

  logic               load, step, last_bit;
  logic               fa_s, fa_c;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  fa_cell u_fa (
    .a   (a_sh_reg[0]),
    .b   (b_sh_reg[0]),
    .cin (carry_reg),
    .s   (fa_s),
    .c   (fa_c)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // start is only looked at in IDLE, so requests during RUN/DONE are dropped.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (load) begin
      cnt_reg   <= '0;
      a_sh_reg  <= bus.a;
      b_sh_reg  <= b_load;
      sum_reg   <= '0;
      carry_reg <= carry_load;
    end else if (step) begin
      cnt_reg   <= cnt_reg + 1'b1;
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
      carry_reg <= fa_c;
      if (last_bit) cout_reg <= fa_c;
    end
  end

  assign bus.busy = (state_reg != ST_IDLE);
  assign bus.done = (state_reg == ST_DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl: an 8-bit instance for latency,
//   handshake, reset and (with SERIAL_ADD_SUB_EN) subtract vectors, and a
//   4-bit instance swept over every a/b/cin combination.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive8(input logic st, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb);
    bus8.start = st;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub   = sb;
`else
    if (sb) $display("note: sub requested in add-only build");
`endif
  endtask

  // Called at the negedge right after the accepting edge; returns the
  // number of edges until done is seen.
  task automatic wait_done8(output int n);
    n = 0;
    while (!bus8.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic sb,
                     input logic [7:0] es, input logic ec);
    int n;
    int busy_n;
    @(negedge clk);
    drive8(1'b1, av, bv, ci, sb);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n = 0;
    busy_n = 0;
    while (!bus8.done && n < 40) begin
      if (bus8.busy) busy_n++;
      @(negedge clk);
      n++;
    end
    if (bus8.busy) busy_n++;
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_sum"}, bus8.sum, es);
    check({tag, "_cout"}, bus8.cout, ec);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus8.done, 0);
    check({tag, "_idle"}, bus8.busy, 0);
    check({tag, "_sum_hold"}, bus8.sum, es);
    $display("op8 %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d", tag, av, bv, ci, sb,
             bus8.sum, bus8.cout);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic ci);
    logic [4:0] exp;
    int n;
    exp = {1'b0, av} + {1'b0, bv} + {4'b0, ci};
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a = av;
    bus4.b = bv;
    bus4.cin = ci;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a = ~av;
    bus4.b = ~bv;
    n = 0;
    while (!bus4.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sw_latency", n, 4);
    check("sw_sum", bus4.sum, exp[3:0]);
    check("sw_cout", bus4.cout, exp[4]);
    @(negedge clk);
    @(negedge clk);
    check("sw_hold", {bus4.cout, bus4.sum}, exp);
  endtask

  initial begin
    int n;
    int pulses;
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus4.start = 1'b0;
    bus4.a = 4'h0;
    bus4.b = 4'h0;
    bus4.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus4.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus8.busy, 0);

    op8("zero",   8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    op8("ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    op8("a5_5a",  8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);

    // Reset while bit 4 is about to be processed; cout is 1 beforehand.
    @(negedge clk);
    drive8(1'b1, 8'h55, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", bus8.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus8.busy, 0);
    check("mid_rst_done", bus8.done, 0);
    check("mid_rst_sum", bus8.sum, 0);
    check("mid_rst_cout", bus8.cout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    op8("after_rst", 8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 1'b0);

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    drive8(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive8(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done8(n);
    check("hs_latency", n, 5);
    check("hs_sum", bus8.sum, 8'h46);
    check("hs_cout", bus8.cout, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) pulses++;
    end
    check("hs_single_done", pulses, 0);
    $display("handshake 12+34 -> sum=%h cout=%0d", bus8.sum, bus8.cout);

    // start held high: re-accepted in the IDLE cycle after DONE, so done
    // pulses are WIDTH+2 edges apart.
    @(negedge clk);
    drive8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    wait_done8(n);
    check("b2b_sum1", bus8.sum, 8'h03);
    @(negedge clk);
    wait_done8(n);
    check("b2b_gap", n + 1, 10);
    check("b2b_sum2", bus8.sum, 8'h03);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_stop", bus8.busy, 0);
    $display("back-to-back gap=%0d", n + 1);

`ifdef SERIAL_ADD_SUB_EN
    op8("sub_10_01",     8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    op8("sub_01_02",     8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    op8("sub_01_02_ci",  8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    op8("sub_10_01_ci",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    op8("sub0_add",      8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          op4(4'(i), 4'(j), 1'(k));
        end
      end
    end
    $display("sweep4 done after %0d checks", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
